// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file (mstatus/mtvec/mscratch/mepc/mcause)
// with an ecall/mret trap sequencer that issues a one-cycle fetch redirect.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_valid/i_ecall/i_mret  retiring instruction and its trap decode
//   i_pc                    PC of the retiring instruction
//   i_csr_we/addr/wdata     CSR write port (address shared with the read port)
//   o_csr_rdata             combinational CSR read of i_csr_addr
//   o_redirect/_pc          one-cycle redirect pulse and its target
//   o_busy                  trap or return in progress; retirement is held
module csr_trap_unit #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic        i_ecall,
    input  logic        i_mret,
    input  logic [31:0] i_pc,
    input  logic        i_csr_we,
    input  logic [11:0] i_csr_addr,
    input  logic [31:0] i_csr_wdata,
    output logic [31:0] o_csr_rdata,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc,
    output logic        o_busy
);
    typedef enum logic [1:0] {IDLE, ENTER, RETURN, DRAIN} state_e;

    state_e      state_q, state_d;
    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d;
    logic        take_ecall, take_mret, trap;

    // ecall has priority when both decode bits are set
    assign take_ecall = state_q == IDLE && i_valid && i_ecall;
    assign take_mret  = state_q == IDLE && i_valid && i_mret && !i_ecall;
    assign trap       = take_ecall || take_mret;

    always_comb begin
        state_d    = state_q;
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        case (state_q)
            IDLE:          state_d = take_ecall ? ENTER : take_mret ? RETURN : IDLE;
            ENTER, RETURN: state_d = DRAIN;
            default:       state_d = IDLE;
        endcase
        if (i_csr_we) begin
            if (i_csr_addr == 12'h305) mtvec_d = i_csr_wdata & ~32'h3;
            if (i_csr_addr == 12'h340) mscratch_d = i_csr_wdata;
            // trap-owned fields: a coincident trap edge takes precedence over software
            if (!trap) begin
                if (i_csr_addr == 12'h300) begin
                    mie_d  = i_csr_wdata[3];
                    mpie_d = i_csr_wdata[7];
                end
                if (i_csr_addr == 12'h341) mepc_d = i_csr_wdata & ~32'h3;
                if (i_csr_addr == 12'h342) mcause_d = i_csr_wdata;
            end
        end
        if (take_ecall) begin
            mepc_d   = i_pc & ~32'h3;
            mcause_d = ECALL_CAUSE;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end
        if (take_mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= RESET_MTVEC & ~32'h3;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            state_q    <= state_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    // MPP is hardwired to machine mode
    always_comb begin
        case (i_csr_addr)
            12'h300: o_csr_rdata = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
            12'h305: o_csr_rdata = mtvec_q;
            12'h340: o_csr_rdata = mscratch_q;
            12'h341: o_csr_rdata = mepc_q;
            12'h342: o_csr_rdata = mcause_q;
            default: o_csr_rdata = '0;
        endcase
    end

    assign o_redirect    = state_q == ENTER || state_q == RETURN;
    assign o_redirect_pc = state_q == ENTER ? mtvec_q : state_q == RETURN ? mepc_q : '0;
    assign o_busy        = state_q != IDLE;
endmodule

// File: doc/csr_trap_unit.md
CSR_TRAP_UNIT -- requirements
Module: csr_trap_unit

Interface
REQ-001 SHALL have parameter RESET_MTVEC, default 32'h0000_0000: mtvec value after reset.
REQ-002 SHALL have parameter ECALL_CAUSE, default 32'd11: mcause value written on ecall (environment call from M-mode).
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 i_valid  input  1  an instruction is retiring this cycle.
REQ-006 i_ecall  input  1  the retiring instruction is ecall (from exception decode).
REQ-007 i_mret  input  1  the retiring instruction is mret (from exception decode).
REQ-008 i_pc  input  32  PC of the retiring instruction.
REQ-009 i_csr_we  input  1  CSR write strobe.
REQ-010 i_csr_addr  input  12  CSR address, shared by read and write.
REQ-011 i_csr_wdata  input  32  CSR write data.
REQ-012 o_csr_rdata  output  32  combinational read of i_csr_addr.
REQ-013 o_redirect  output  1  one-cycle fetch redirect pulse.
REQ-014 o_redirect_pc  output  32  redirect target, valid while o_redirect=1, else 0.
REQ-015 o_busy  output  1  unit is handling a trap or return; pipeline holds retirement.

Function
REQ-016 SHALL implement CSRs: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342.
- mstatus: only MIE bit 3, MPIE bit 7 and MPP bits 12:11 are stored; MPP reads 2'b11 and is not writable; all other bits read 0.
- mtvec: direct mode only; bits 1:0 read 0.
- mepc: bits 1:0 read 0.
REQ-017 Unimplemented addresses SHALL read 32'h0; writes to them SHALL be ignored.
REQ-018 SHALL use FSM states IDLE, ENTER, RETURN, DRAIN.
REQ-019 IDLE: i_valid & i_ecall -> ENTER; i_valid & i_mret & !i_ecall -> RETURN; otherwise stay.
REQ-020 On the IDLE->ENTER edge, the unit SHALL perform these updates:
- mepc <= {i_pc[31:2],2'b00};
- mcause <= ECALL_CAUSE;
- MPIE <= MIE;
- MIE <= 0.
REQ-021 On the IDLE->RETURN edge, the unit SHALL perform MIE <= MPIE and MPIE <= 1.
REQ-022 ENTER: o_redirect=1, o_redirect_pc={mtvec[31:2],2'b00}, o_busy=1; next state DRAIN.
REQ-023 RETURN: o_redirect=1, o_redirect_pc=mepc (current value), o_busy=1; next state DRAIN.
REQ-024 DRAIN: o_redirect=0, o_busy=1; next state IDLE. Total latency: redirect in cycle N+1, o_busy low again in cycle N+3.
REQ-025 In IDLE, o_busy=0 and o_redirect=0.
REQ-026 i_ecall and i_mret asserted together with i_valid SHALL be treated as ecall (ecall priority).
REQ-027 i_valid, i_ecall and i_mret SHALL be ignored in ENTER, RETURN and DRAIN (no re-trigger, no nesting).
REQ-028 CSR writes SHALL be accepted in every state.
REQ-029 If a CSR write to mepc, mcause or mstatus coincides with an IDLE->ENTER or IDLE->RETURN edge, the trap update SHALL win for those fields and the write is dropped.
REQ-030 A CSR write to mtvec SHALL take effect on the next edge; an ENTER in the following cycle uses the new value.
REQ-031 o_csr_rdata SHALL reflect register contents before the current edge (no write bypass).

Reset
REQ-032 While i_rst_n=0, regardless of clock, the unit SHALL force:
- state=IDLE;
- mstatus reads 32'h0000_1800;
- mtvec=RESET_MTVEC;
- mepc=mcause=mscratch=0;
- o_redirect=0, o_redirect_pc=0, o_busy=0.
REQ-033 Reset asserted mid-ENTER/RETURN/DRAIN SHALL abort the sequence with no further redirect pulse after release.

Verification
REQ-034 Reset release, read all five CSRs -> mstatus 0x1800, mtvec RESET_MTVEC, others 0; o_busy=0.
REQ-035 Scenario: mtvec<=0x100, MIE<=1, then ecall at pc=0x2004.
- Cycle N+1: o_redirect=1, pc 0x100.
- Afterwards: mepc 0x2004, mcause 11, mstatus 0x1880.
- o_busy falls at N+3.
REQ-036 Continue with mret -> o_redirect_pc=0x2004 at N+1; mstatus then 0x1888.
REQ-037 Scenario: ecall and mret high together at pc 0x40 -> ecall taken, mepc 0x40; a second ecall during DRAIN is ignored (exactly one redirect pulse).
REQ-038 Scenario: CSR write mepc<=0x999 in the same cycle as an ecall at pc 0x80 -> mepc reads 0x80. Write 0x123 to mtvec -> reads 0x120.
REQ-039 Scenario: assert i_rst_n=0 during ENTER -> outputs zero immediately; no redirect after release.
